gfx_fetch_sched: RTL and testbench
==================================

// Module: gfx_fetch_sched
// PURPOSE
//  Per-scanline scheduler and arbiter for the shared graphics-ROM port.
//  Derives line/frame start strobes from the video timing outputs (hbl, vbl, vc).
//  Round-robin shares one ROM channel between N layer fetchers (bg0, bg1, fg, sprites).
//  Sits between the video timing generator, the layer renderers and the SDRAM ROM port.
// PARAMETERS
//  N_REQ    4     number of requesters (1..8)
//  AW       24    ROM byte-address width
//  DW       32    ROM data width
//  TIMEOUT  255   cycles to wait for rom_valid before abort; 0 = no timeout
// PORTS
//  clk         in   1         system clock
//  reset       in   1         synchronous, active-high reset
//  clk_pix     in   1         pixel-clock enable, one clk wide
//  hbl         in   1         horizontal blank from the video timing generator
//  vbl         in   1         vertical blank from the video timing generator
//  vc          in   9         current line counter
//  line_start  out  1         1-clk pulse: new line fetch window opens
//  frame_start out  1         1-clk pulse on vbl falling edge
//  line_num    out  9         line to prefetch (vc+1, 9-bit wrap); held until next line_start
//  req         in   N_REQ     per-requester fetch request; level, held until done
//  req_addr    in   N_REQ*AW  flattened addresses; slice i = [i*AW +: AW]
//  done        out  N_REQ     1-clk pulse: requester i's data valid on rd_data
//  err         out  1         with done: fetch aborted by timeout, rd_data = 0
//  rd_data     out  DW        returned ROM data
//  rom_req     out  1         ROM request, held until rom_valid or timeout
//  rom_addr    out  AW        ROM address, stable while rom_req = 1
//  rom_valid   in   1         1-clk pulse: rom_data valid, request finished
//  rom_data    in   DW        ROM read data
//  overrun     out  1         sticky per line: work still pending at line_start
// BEHAVIOUR
//  Reset: all outputs 0; FSM IDLE; round-robin pointer 0; line_num 0.
//  Line timing:
//  - hbl_q/vbl_q are sampled only when clk_pix = 1.
//  - hbl 0->1 seen on a clk_pix cycle: line_start pulses the next clk and line_num <= vc+1 (511 -> 0).
//  - vbl 1->0: frame_start pulses the same way.
//  - Both edges on the same clk_pix: both pulses fire together.
//  FSM IDLE -> BUSY -> RESP -> IDLE:
//  - IDLE: if any req bit is set, grant the first set bit at or after ptr (wrapping).
//    Latch the granted index and address; assert rom_req next clk.
//  - BUSY: hold rom_req/rom_addr. On rom_valid: latch rom_data, drop rom_req, go RESP.
//    If TIMEOUT != 0 and TIMEOUT clks pass in BUSY: drop rom_req, set err, go RESP.
//  - RESP: done[g] pulses for 1 clk with rd_data/err; ptr <= g+1 mod N_REQ; go IDLE.
//  - Best case req->done is 3 clks, plus ROM latency. One transaction in flight at a time.
//  - rom_valid outside BUSY is ignored.
//  Requester rules:
//  - A req dropped before its grant is withdrawn without side effects.
//  - A req dropped after its grant still gets done; its data is discarded by the requester.
//  - A requester must not reassert req in the same clk as its done pulse.
//  Line boundary:
//  - An in-flight fetch is never aborted at line_start; it completes normally.
//  - overrun is cleared on line_start, then set in that same clk if FSM != IDLE or any req = 1.
//  Reset mid-transaction: FSM forced to IDLE; rom_req drops next clk; no done is issued.
// CONFIGURATION
//  Macro GFX_FETCH_STATS_EN:
//  - Defined: adds output stat_overruns[15:0], a saturating count of overrun lines per frame.
//    It latches and clears on frame_start. Also adds stat_busy[15:0], the clk count of FSM != IDLE
//    over the previous line, latched on line_start.
//  - Undefined: those ports and counters are absent; all other behaviour is identical.
// STRUCTURE
//  Shared package (gfx_pkg): FSM state enum {IDLE, BUSY, RESP}, requester index constants
//  (REQ_BG0 = 0, REQ_BG1 = 1, REQ_FG = 2, REQ_SPR = 3), ROM AW/DW defaults.
//  One sub-module: rr_arbiter (req vector + ptr -> one-hot grant + index), combinational.
//  Edge detection, FSM and timeout counter stay in this module.
// TESTING
//  1. hbl rises with clk_pix while vc = 100 -> line_start pulse one clk later; line_num = 101.
//  2. vc = 511 at hbl rise -> line_num = 0. vbl falls -> single frame_start pulse.
//  3. req = 4'b1111 held; ROM returns rom_valid 5 clks after each rom_req; ptr starts at 0 ->
//     done order 0, 1, 2, 3, 0; rom_addr matches each slice; rd_data echoes rom_data.
//  4. req[2] alone; rom_valid never comes; TIMEOUT = 8 -> rom_req drops after 8 clks;
//     done[2] and err = 1 in the same clk; rd_data = 0.
//  5. Fetch in BUSY when line_start fires -> overrun = 1; the fetch still completes with done.
//  6. reset asserted during BUSY -> rom_req = 0 next clk; no done; req[1] after reset is granted first.

Source files
------------

// File: rtl/gfx_pkg.sv
// Shared definitions for the graphics ROM fetch scheduler: FSM states,
// requester slot assignments and default ROM bus widths.
package gfx_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } fetch_state_t;

    localparam int REQ_BG0 = 0;
    localparam int REQ_BG1 = 1;
    localparam int REQ_FG  = 2;
    localparam int REQ_SPR = 3;

    localparam int ROM_AW = 24;
    localparam int ROM_DW = 32;

    // Width of an index into n requesters, never less than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/gfx_fetch_sched_rr_arbiter.sv
// Combinational round-robin pick: the first set request bit at or after
// ptr, wrapping around, returned as a one-hot grant and a binary index.
module rr_arbiter
    import gfx_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IW    = idx_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [IW-1:0]    idx,
    output logic             valid
);

    logic [IW:0] sum;

    // Scan requesters starting at ptr; the first hit wins.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        valid = 1'b0;
        sum   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            sum = {1'b0, ptr} + (IW+1)'(i);
            if (sum >= (IW+1)'(N_REQ)) begin
                sum = sum - (IW+1)'(N_REQ);
            end
            if (!valid && req[sum[IW-1:0]]) begin
                valid              = 1'b1;
                gnt[sum[IW-1:0]]   = 1'b1;
                idx                = sum[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/gfx_fetch_sched.sv
// Per-scanline scheduler and round-robin arbiter for the shared graphics
// ROM port. Derives line/frame strobes from video timing and serialises
// layer fetches, one ROM transaction in flight at a time.
// Optional statistics counters are enabled by defining GFX_FETCH_STATS_EN.
module gfx_fetch_sched
    import gfx_pkg::*;
#(
    parameter int N_REQ   = REQ_SPR + 1,
    parameter int AW      = ROM_AW,
    parameter int DW      = ROM_DW,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clk_pix,
    input  logic                hbl,
    input  logic                vbl,
    input  logic [8:0]          vc,
    output logic                line_start,
    output logic                frame_start,
    output logic [8:0]          line_num,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ*AW-1:0] req_addr,
    output logic [N_REQ-1:0]    done,
    output logic                err,
    output logic [DW-1:0]       rd_data,
    output logic                rom_req,
    output logic [AW-1:0]       rom_addr,
    input  logic                rom_valid,
    input  logic [DW-1:0]       rom_data,
    output logic                overrun
`ifdef GFX_FETCH_STATS_EN
    ,
    output logic [15:0]         stat_overruns,
    output logic [15:0]         stat_busy
`endif
);

    localparam int IW = idx_width(N_REQ);
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    // Video timing tracking
    logic       hbl_q, hbl_d;
    logic       vbl_q, vbl_d;
    logic       line_start_q, line_start_d;
    logic       frame_start_q, frame_start_d;
    logic [8:0] line_num_q, line_num_d;
    logic       overrun_q, overrun_d;

    // Fetch FSM
    fetch_state_t     state_q, state_d;
    logic [IW-1:0]    ptr_q, ptr_d;
    logic [IW-1:0]    gnt_idx_q, gnt_idx_d;
    logic [N_REQ-1:0] gnt_oh_q, gnt_oh_d;
    logic             rom_req_q, rom_req_d;
    logic [AW-1:0]    rom_addr_q, rom_addr_d;
    logic [TW-1:0]    tmo_q, tmo_d;
    logic [N_REQ-1:0] done_q, done_d;
    logic             err_q, err_d;
    logic [DW-1:0]    rd_data_q, rd_data_d;

    logic [N_REQ-1:0] arb_gnt;
    logic [IW-1:0]    arb_idx;
    logic             arb_valid;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_arb (
        .req   (req),
        .ptr   (ptr_q),
        .gnt   (arb_gnt),
        .idx   (arb_idx),
        .valid (arb_valid)
    );

    // Blanking edges are only meaningful on pixel-enable cycles; the strobes
    // appear the clock after the edge is seen. overrun re-evaluates per line.
    always_comb begin
        hbl_d = hbl_q;
        vbl_d = vbl_q;
        if (clk_pix) begin
            hbl_d = hbl;
            vbl_d = vbl;
        end
        line_start_d  = clk_pix & hbl & ~hbl_q;
        frame_start_d = clk_pix & ~vbl & vbl_q;
        line_num_d    = line_start_d ? (vc + 9'd1) : line_num_q;
        overrun_d     = overrun_q;
        if (line_start_q) begin
            overrun_d = (state_q != IDLE) | (|req);
        end
    end

    // Register the video timing strobes and the per-line overrun flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            hbl_q         <= 1'b0;
            vbl_q         <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            line_num_q    <= '0;
            overrun_q     <= 1'b0;
        end else begin
            hbl_q         <= hbl_d;
            vbl_q         <= vbl_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            line_num_q    <= line_num_d;
            overrun_q     <= overrun_d;
        end
    end

    // IDLE grants a requester, BUSY waits for the ROM or the timeout,
    // RESP presents done for one clock and advances the round-robin pointer.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        gnt_idx_d  = gnt_idx_q;
        gnt_oh_d   = gnt_oh_q;
        rom_req_d  = rom_req_q;
        rom_addr_d = rom_addr_q;
        tmo_d      = tmo_q;
        done_d     = '0;
        err_d      = 1'b0;
        rd_data_d  = rd_data_q;
        case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    state_d    = BUSY;
                    gnt_idx_d  = arb_idx;
                    gnt_oh_d   = arb_gnt;
                    rom_req_d  = 1'b1;
                    rom_addr_d = req_addr[arb_idx*AW +: AW];
                    tmo_d      = '0;
                end
            end
            BUSY: begin
                if (rom_valid) begin
                    state_d   = RESP;
                    rom_req_d = 1'b0;
                    rd_data_d = rom_data;
                    done_d    = gnt_oh_q;
                end else if ((TIMEOUT != 0) && (tmo_q == TW'(TIMEOUT - 1))) begin
                    state_d   = RESP;
                    rom_req_d = 1'b0;
                    rd_data_d = '0;
                    err_d     = 1'b1;
                    done_d    = gnt_oh_q;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
                ptr_d   = (gnt_idx_q == IW'(N_REQ - 1)) ? '0 : (gnt_idx_q + 1'b1);
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Fetch FSM state and its registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            gnt_idx_q  <= '0;
            gnt_oh_q   <= '0;
            rom_req_q  <= 1'b0;
            rom_addr_q <= '0;
            tmo_q      <= '0;
            done_q     <= '0;
            err_q      <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            gnt_idx_q  <= gnt_idx_d;
            gnt_oh_q   <= gnt_oh_d;
            rom_req_q  <= rom_req_d;
            rom_addr_q <= rom_addr_d;
            tmo_q      <= tmo_d;
            done_q     <= done_d;
            err_q      <= err_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign line_num    = line_num_q;
    assign overrun     = overrun_q;
    assign done        = done_q;
    assign err         = err_q;
    assign rd_data     = rd_data_q;
    assign rom_req     = rom_req_q;
    assign rom_addr    = rom_addr_q;

`ifdef GFX_FETCH_STATS_EN
    logic [15:0] busy_cnt_q, busy_cnt_d;
    logic [15:0] stat_busy_q, stat_busy_d;
    logic [15:0] ovr_cnt_q, ovr_cnt_d;
    logic [15:0] stat_ovr_q, stat_ovr_d;
    logic [15:0] ovr_inc;

    // Saturating busy-cycle count per line and overrun-line count per frame.
    always_comb begin
        stat_busy_d = stat_busy_q;
        stat_ovr_d  = stat_ovr_q;
        busy_cnt_d  = busy_cnt_q;
        if ((state_q != IDLE) && (busy_cnt_q != 16'hFFFF)) begin
            busy_cnt_d = busy_cnt_q + 16'd1;
        end
        if (line_start_q) begin
            stat_busy_d = busy_cnt_q;
            busy_cnt_d  = (state_q != IDLE) ? 16'd1 : 16'd0;
        end
        ovr_inc = ovr_cnt_q;
        if (line_start_q && overrun_d && (ovr_cnt_q != 16'hFFFF)) begin
            ovr_inc = ovr_cnt_q + 16'd1;
        end
        ovr_cnt_d = ovr_inc;
        if (frame_start_q) begin
            stat_ovr_d = ovr_inc;
            ovr_cnt_d  = '0;
        end
    end

    // Register the statistics counters and their latched snapshots.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_cnt_q  <= '0;
            stat_busy_q <= '0;
            ovr_cnt_q   <= '0;
            stat_ovr_q  <= '0;
        end else begin
            busy_cnt_q  <= busy_cnt_d;
            stat_busy_q <= stat_busy_d;
            ovr_cnt_q   <= ovr_cnt_d;
            stat_ovr_q  <= stat_ovr_d;
        end
    end

    assign stat_overruns = stat_ovr_q;
    assign stat_busy     = stat_busy_q;
`endif

endmodule

// File: tb/tb_gfx_fetch_sched.sv
// Self-checking bench for gfx_fetch_sched: table-driven line timing vectors,
// then scoreboarded ROM fetch sequences (round robin, timeout, overrun, reset).
module tb_gfx_fetch_sched;
    import gfx_pkg::*;

    localparam int NR  = 4;
    localparam int AWT = 24;
    localparam int DWT = 32;
    localparam int LAT = 5;

    logic            clk;
    logic            reset;
    logic            clk_pix;
    logic            hbl;
    logic            vbl;
    logic [8:0]      vc;
    logic            line_start;
    logic            frame_start;
    logic [8:0]      line_num;
    logic [NR-1:0]   req;
    logic [NR*AWT-1:0] req_addr;
    logic [NR-1:0]   done;
    logic            err;
    logic [DWT-1:0]  rd_data;
    logic            rom_req;
    logic [AWT-1:0]  rom_addr;
    logic            rom_valid;
    logic [DWT-1:0]  rom_data;
    logic            overrun;

    gfx_fetch_sched #(
        .N_REQ   (NR),
        .AW      (AWT),
        .DW      (DWT),
        .TIMEOUT (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .clk_pix     (clk_pix),
        .hbl         (hbl),
        .vbl         (vbl),
        .vc          (vc),
        .line_start  (line_start),
        .frame_start (frame_start),
        .line_num    (line_num),
        .req         (req),
        .req_addr    (req_addr),
        .done        (done),
        .err         (err),
        .rd_data     (rd_data),
        .rom_req     (rom_req),
        .rom_addr    (rom_addr),
        .rom_valid   (rom_valid),
        .rom_data    (rom_data),
        .overrun     (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       pix;
        logic       hbl;
        logic       vbl;
        logic [8:0] vc;
        logic       exp_ls;
        logic       exp_fs;
        logic [8:0] exp_ln;
    } line_vec_t;

    typedef struct {
        logic [NR-1:0]  done;
        logic           err;
        logic [DWT-1:0] data;
        logic [AWT-1:0] addr;
    } exp_t;

    line_vec_t      vecs[13];
    exp_t           exp_q[$];
    exp_t           mon_e;
    logic [AWT-1:0] addr_tab[NR];
    logic           rom_en;
    int             rom_cnt;
    int             n_checks = 0;
    int             n_fails  = 0;
    int             n_done   = 0;

    function automatic logic [DWT-1:0] romWord(input logic [AWT-1:0] a);
        return {~a[7:0], a};
    endfunction

    function automatic line_vec_t mkVec(input logic p, input logic h, input logic v,
                                        input logic [8:0] c, input logic ls,
                                        input logic fs, input logic [8:0] ln);
        line_vec_t r;
        r.pix = p; r.hbl = h; r.vbl = v; r.vc = c;
        r.exp_ls = ls; r.exp_fs = fs; r.exp_ln = ln;
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act,
                               input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, expv);
        end
    endtask

    // Drive one pixel-enable cycle, check the strobes one clock later,
    // then check that they were single-clock pulses.
    task automatic applyStimulus(input line_vec_t v);
        @(negedge clk);
        clk_pix = v.pix;
        hbl     = v.hbl;
        vbl     = v.vbl;
        vc      = v.vc;
        @(negedge clk);
        clk_pix = 1'b0;
        checkOutput("line_start", line_start, v.exp_ls);
        checkOutput("frame_start", frame_start, v.exp_fs);
        checkOutput("line_num", line_num, v.exp_ln);
        @(negedge clk);
        checkOutput("line_start width", line_start, 1'b0);
        checkOutput("frame_start width", frame_start, 1'b0);
    endtask

    task automatic pushExp(input int idx, input logic e_err);
        exp_t e;
        e.done = NR'(1 << idx);
        e.err  = e_err;
        e.addr = addr_tab[idx];
        e.data = e_err ? '0 : romWord(addr_tab[idx]);
        exp_q.push_back(e);
    endtask

    task automatic waitDones(input int count, input int budget);
        int target;
        target = n_done + count;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            #1;
            if (n_done >= target) return;
        end
        checkOutput("done wait budget", n_done, target);
    endtask

    task automatic waitRomReq(input int budget);
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            #1;
            if (rom_req) return;
        end
        checkOutput("rom_req wait budget", rom_req, 1'b1);
    endtask

    // Scoreboard: every done pulse is matched against the oldest expectation.
    always @(negedge clk) begin
        if (done !== '0) begin
            n_done++;
            if (exp_q.size() == 0) begin
                checkOutput("unexpected done", done, '0);
            end else begin
                mon_e = exp_q.pop_front();
                checkOutput("done index", done, mon_e.done);
                checkOutput("err", err, mon_e.err);
                checkOutput("rd_data", rd_data, mon_e.data);
            end
        end
    end

    // ROM model: answers LAT clocks after rom_req rises when enabled.
    initial begin
        rom_valid = 1'b0;
        rom_data  = '0;
        rom_cnt   = 0;
        forever begin
            @(negedge clk);
            if (rom_valid) begin
                rom_valid = 1'b0;
                rom_cnt   = 0;
            end else if (rom_req && rom_en) begin
                rom_cnt++;
                if (rom_cnt == LAT) begin
                    rom_valid = 1'b1;
                    rom_data  = romWord(rom_addr);
                    rom_cnt   = 0;
                    if (exp_q.size() > 0) begin
                        checkOutput("rom_addr", rom_addr, exp_q[0].addr);
                    end
                end
            end else begin
                rom_cnt = 0;
            end
        end
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int hi;
        reset   = 1'b1;
        clk_pix = 1'b0;
        hbl     = 1'b0;
        vbl     = 1'b0;
        vc      = '0;
        req     = '0;
        rom_en  = 1'b0;
        addr_tab[REQ_BG0] = 24'h010203;
        addr_tab[REQ_BG1] = 24'h0A0B0C;
        addr_tab[REQ_FG]  = 24'h123456;
        addr_tab[REQ_SPR] = 24'hFEDCBA;
        req_addr = {addr_tab[3], addr_tab[2], addr_tab[1], addr_tab[0]};

        vecs[0]  = mkVec(1, 0, 0, 9'd99,  0, 0, 9'd0);
        vecs[1]  = mkVec(1, 1, 0, 9'd100, 1, 0, 9'd101);
        vecs[2]  = mkVec(1, 1, 0, 9'd100, 0, 0, 9'd101);
        vecs[3]  = mkVec(1, 0, 0, 9'd100, 0, 0, 9'd101);
        vecs[4]  = mkVec(1, 1, 0, 9'd511, 1, 0, 9'd0);
        vecs[5]  = mkVec(1, 0, 1, 9'd0,   0, 0, 9'd0);
        vecs[6]  = mkVec(1, 0, 0, 9'd1,   0, 1, 9'd0);
        vecs[7]  = mkVec(1, 0, 0, 9'd2,   0, 0, 9'd0);
        vecs[8]  = mkVec(1, 0, 1, 9'd200, 0, 0, 9'd0);
        vecs[9]  = mkVec(1, 1, 0, 9'd239, 1, 1, 9'd240);
        vecs[10] = mkVec(1, 0, 0, 9'd240, 0, 0, 9'd240);
        vecs[11] = mkVec(0, 1, 0, 9'd50,  0, 0, 9'd240);
        vecs[12] = mkVec(1, 1, 0, 9'd50,  1, 0, 9'd51);

        repeat (3) @(negedge clk);
        checkOutput("reset line_start", line_start, 1'b0);
        checkOutput("reset frame_start", frame_start, 1'b0);
        checkOutput("reset line_num", line_num, 9'd0);
        checkOutput("reset done", done, '0);
        checkOutput("reset err", err, 1'b0);
        checkOutput("reset rd_data", rd_data, '0);
        checkOutput("reset rom_req", rom_req, 1'b0);
        checkOutput("reset rom_addr", rom_addr, '0);
        checkOutput("reset overrun", overrun, 1'b0);
        reset = 1'b0;

        $display("[TB] line timing vectors");
        foreach (vecs[i]) applyStimulus(vecs[i]);
        checkOutput("overrun idle lines", overrun, 1'b0);

        $display("[TB] round robin with all requesters");
        rom_en = 1'b1;
        pushExp(REQ_BG0, 1'b0);
        pushExp(REQ_BG1, 1'b0);
        pushExp(REQ_FG,  1'b0);
        pushExp(REQ_SPR, 1'b0);
        pushExp(REQ_BG0, 1'b0);
        @(negedge clk);
        req = 4'b1111;
        waitDones(5, 200);
        req = '0;
        repeat (3) @(negedge clk);

        $display("[TB] timeout on fg");
        rom_en = 1'b0;
        pushExp(REQ_FG, 1'b1);
        req = 4'b0100;
        hi  = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            #1;
            if (rom_req) hi++;
            if (exp_q.size() == 0) break;
        end
        checkOutput("timeout done seen", exp_q.size(), 0);
        checkOutput("rom_req high clks", hi, 8);
        req = '0;
        repeat (3) @(negedge clk);

        $display("[TB] line start during busy fetch");
        rom_en = 1'b1;
        applyStimulus(mkVec(1, 0, 0, 9'd10, 0, 0, 9'd51));
        pushExp(REQ_BG1, 1'b0);
        req = 4'b0010;
        waitRomReq(20);
        applyStimulus(mkVec(1, 1, 0, 9'd10, 1, 0, 9'd11));
        checkOutput("overrun busy", overrun, 1'b1);
        waitDones(1, 40);
        req = '0;
        repeat (2) @(negedge clk);
        checkOutput("overrun sticky", overrun, 1'b1);
        applyStimulus(mkVec(1, 0, 0, 9'd20, 0, 0, 9'd11));
        applyStimulus(mkVec(1, 1, 0, 9'd20, 1, 0, 9'd21));
        checkOutput("overrun cleared", overrun, 1'b0);

        $display("[TB] reset during busy fetch");
        rom_en = 1'b0;
        req    = 4'b0100;
        waitRomReq(20);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("rom_req after reset", rom_req, 1'b0);
        checkOutput("done after reset", done, '0);
        checkOutput("line_num after reset", line_num, 9'd0);
        req    = 4'b0110;
        reset  = 1'b0;
        rom_en = 1'b1;
        pushExp(REQ_BG1, 1'b0);
        waitDones(1, 40);
        req = '0;
        repeat (4) @(negedge clk);
        checkOutput("scoreboard drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
